// File: rtl/arm_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | arm_ctrl_pkg                                                             |
// | Shared types and widths for the pipeline stall/flush controller.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package arm_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } ctrl_state_e;

  // Wide enough to hold 0..max_wait inclusive.
  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// +--------------------------------------------------------------------------+
// | hazard_detect                                                            |
// | RAW compare of ID sources against EXE/MEM destinations.                  |
// | Macro FORWARDING_EN: only load-use in EXE stalls, MEM term dropped.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import arm_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_src1_vld,
  input  logic                 id_src2_vld,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hz
);

  logic w_src1_hz;
  logic w_src2_hz;
  logic w_unused;

`ifdef FORWARDING_EN
  // Forwarding covers ALU results; only a load still in EXE can't be bypassed.
  assign w_src1_hz = id_src1_vld & exe_wb_en & exe_mem_r_en & (id_src1 == exe_dest);
  assign w_src2_hz = id_src2_vld & exe_wb_en & exe_mem_r_en & (id_src2 == exe_dest);
  assign w_unused  = &{1'b0, mem_dest, mem_wb_en};
`else
  assign w_src1_hz = id_src1_vld & (((id_src1 == exe_dest) & exe_wb_en) |
                                    ((id_src1 == mem_dest) & mem_wb_en));
  assign w_src2_hz = id_src2_vld & (((id_src2 == exe_dest) & exe_wb_en) |
                                    ((id_src2 == mem_dest) & mem_wb_en));
  assign w_unused  = &{1'b0, exe_mem_r_en};
`endif

  assign hz = w_src1_hz | w_src2_hz;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipeline_ctrl                                                            |
// | Stall/flush controller: RAW hazards, branch flush, SRAM wait FSM and a   |
// | saturating stall counter. Macro FORWARDING_EN selects load-use-only RAW. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_src1_vld,
  input  logic                 id_src2_vld,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 hz_freeze,
  output logic                 id_flush,
  output logic                 if_flush,
  output logic                 pipe_freeze,
  output logic                 sram_start,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int c_wait_w = wait_cnt_w(MAX_WAIT);

  ctrl_state_e         r_state;
  ctrl_state_e         w_state_next;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_sram_start;
  logic                r_timeout_err;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_hz;
  logic                w_pipe_freeze;
  logic                w_timeout;
  logic                w_stall;

  hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_vld  (id_src1_vld),
    .id_src2_vld  (id_src2_vld),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hz           (w_hz)
  );

  // The last permitted ACCESS cycle ends in timeout unless mem_ready arrives in it.
  assign w_timeout = (r_state == ACCESS) && !mem_ready &&
                     (r_wait_cnt == c_wait_w'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pipe_freeze = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        w_pipe_freeze = 1'b1;
        if (mem_ready || w_timeout) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_sram_start  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt   <= (r_state == ACCESS) ? r_wait_cnt + c_wait_w'(1) : '0;
      r_sram_start <= (r_state == IDLE) && mem_req;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // A frozen pipe holds everything; branch/hazard decisions wait for release.
  assign pipe_freeze = w_pipe_freeze;
  assign hz_freeze   = !w_pipe_freeze && w_hz && !branch_taken;
  assign if_flush    = !w_pipe_freeze && branch_taken;
  assign id_flush    = !w_pipe_freeze && (branch_taken || w_hz);

  assign w_stall = hz_freeze || pipe_freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign sram_start  = r_sram_start;
  assign timeout_err = r_timeout_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipeline_ctrl                                                         |
// | Directed bench with a cycle model of the controller rules.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
  logic             id_src1_vld, id_src2_vld, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             branch_taken, mem_req, mem_ready;
  logic             hz_freeze, id_flush, if_flush, pipe_freeze, sram_start, timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_vld  (id_src1_vld),
    .id_src2_vld  (id_src2_vld),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .hz_freeze    (hz_freeze),
    .id_flush     (id_flush),
    .if_flush     (if_flush),
    .pipe_freeze  (pipe_freeze),
    .sram_start   (sram_start),
    .timeout_err  (timeout_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: read-after-write rule for one source register.
  function automatic bit raw(input logic [3:0] s, input logic v);
`ifdef FORWARDING_EN
    return v && (s == exe_dest) && exe_wb_en && exe_mem_r_en;
`else
    return v && (((s == exe_dest) && exe_wb_en) || ((s == mem_dest) && mem_wb_en));
`endif
  endfunction

  bit m_busy    = 1'b0;  // memory access outstanding, pipe held
  bit m_release = 1'b0;  // one-cycle release after access ends
  bit m_start   = 1'b0;
  bit m_to      = 1'b0;
  int m_acc     = 0;     // access cycles already spent
  int m_stall   = 0;

  function automatic bit hz_any();
    return raw(id_src1, id_src1_vld) || raw(id_src2, id_src2_vld);
  endfunction

  function automatic bit exp_hzf();
    return !m_busy && hz_any() && !branch_taken;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy    <= 1'b0;
      m_release <= 1'b0;
      m_start   <= 1'b0;
      m_to      <= 1'b0;
      m_acc     <= 0;
      m_stall   <= 0;
    end else begin
      if (exp_hzf() || m_busy) m_stall <= (m_stall < SAT) ? m_stall + 1 : SAT;
      m_start <= !m_busy && !m_release && mem_req;
      if (m_busy) begin
        m_acc <= m_acc + 1;
        if (mem_ready || (m_acc + 1 == MAX_WAIT)) begin
          m_busy    <= 1'b0;
          m_release <= 1'b1;
          if (!mem_ready) m_to <= 1'b1;
        end
      end else if (m_release) begin
        m_release <= 1'b0;
      end else if (mem_req) begin
        m_busy <= 1'b1;
        m_acc  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    bit f, h, b;
    f = m_busy;
    h = hz_any();
    b = branch_taken;
    check("pipe_freeze", pipe_freeze, f);
    check("hz_freeze",   hz_freeze,   !f && h && !b);
    check("if_flush",    if_flush,    !f && b);
    check("id_flush",    id_flush,    !f && (h || b));
    check("sram_start",  sram_start,  m_start);
    check("timeout_err", timeout_err, m_to);
    check("stall_cnt",   stall_cnt,   m_stall);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    id_src1_vld = 1'b0; id_src2_vld = 1'b0; exe_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pipe_freeze", pipe_freeze, 0);
    check("rst_sram_start",  sram_start,  0);
    check("rst_timeout",     timeout_err, 0);
    check("rst_stall_cnt",   stall_cnt,   0);
    rst = 1'b1;

    // RAW on src1 against EXE
    id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; #1;
`ifdef FORWARDING_EN
    check("t1_alu_fwd_no_hz", hz_freeze, 0);
`else
    check("t1_raw_exe_hz", hz_freeze, 1);
`endif
    exe_mem_r_en = 1'b1; #1;
    check("t1_load_use_hz", hz_freeze, 1);
    check("t1_load_use_id", id_flush,  1);
    check("t1_load_use_if", if_flush,  0);
    // RAW on src2 against MEM
    id_src1_vld = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    id_src2 = 4'd5; id_src2_vld = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1; #1;
`ifdef FORWARDING_EN
    check("t1_mem_fwd_no_hz", hz_freeze, 0);
`else
    check("t1_raw_mem_hz", hz_freeze, 1);
`endif
    id_src2_vld = 1'b0; #1;
    check("t1_invalid_src_no_hz", hz_freeze, 0);
    // branch beats hazard
    id_src1_vld = 1'b1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; branch_taken = 1'b1; #1;
    check("t2_br_if_flush", if_flush,  1);
    check("t2_br_id_flush", id_flush,  1);
    check("t2_br_no_hz",    hz_freeze, 0);
    step();
    clear_in();
    rst = 1'b0;
    step();
    rst = 1'b1;

    // SRAM access, ready on third ACCESS cycle
    mem_req = 1'b1;
    step();
    mem_req = 1'b0; #1;
    check("t3_start_pulse", sram_start,  1);
    check("t3_freeze_on",   pipe_freeze, 1);
    step();
    check("t3_start_once",  sram_start,  0);
    id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    exe_mem_r_en = 1'b1; branch_taken = 1'b1; #1;
    check("t3_frozen_no_hz", hz_freeze, 0);
    check("t3_frozen_no_if", if_flush,  0);
    check("t3_frozen_no_id", id_flush,  0);
    step();
    clear_in();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; #1;
    check("t3_done_release", pipe_freeze, 0);
    check("t3_stall_cnt",    stall_cnt,   3);
    mem_req = 1'b1;      // ignored in DONE
    step();
    mem_req = 1'b0; mem_ready = 1'b1; #1;
    check("t3_done_ignores_req", sram_start, 0);
    step();
    mem_ready = 1'b0; #1;
    check("t3_idle_ignores_ready", pipe_freeze, 0);

    // timeout after MAX_WAIT ACCESS cycles
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    repeat (3) step();
    check("t4_still_waiting", pipe_freeze, 1);
    check("t4_no_timeout_yet", timeout_err, 0);
    step();
    check("t4_timeout_release", pipe_freeze, 0);
    check("t4_timeout_set",     timeout_err, 1);
    check("t4_stall_cnt",       stall_cnt,   7);
    repeat (3) step();
    check("t4_timeout_sticky",  timeout_err, 1);

    // async reset mid-ACCESS
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    check("t5_freeze_drops", pipe_freeze, 0);
    check("t5_stall_clear",  stall_cnt,   0);
    check("t5_timeout_clear", timeout_err, 0);
    check("t5_no_start",     sram_start,  0);
    step();
    rst = 1'b1;
    repeat (2) step();
    check("t5_no_restart", sram_start, 0);

    // saturation
    id_src1 = 4'd7; id_src1_vld = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    repeat (10) step();
    check("t6_count_10", stall_cnt, 10);
    repeat (10) step();
    check("t6_saturated", stall_cnt, SAT);
    clear_in();
    step();
    check("t6_holds", stall_cnt, SAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
